divisor_param: RTL and testbench

- Parametrised successor to the team's 32-bit restoring divider.
- Iterative restoring division of configurable width W, one quotient bit per clock.
- Signed or unsigned mode selected per operation; divide-by-zero flagged explicitly.
- Start/Busy/Done handshake; sits as a multi-cycle arithmetic unit behind a datapath controller.

---
 rtl/divisor_param.sv | 241 ++++++++++++++++++++++++
 tb/tb_divisor_param.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_param.sv
// -----------------------------------------------------------------------------
// divisor_param
// Iterative restoring divider of configurable width W. It produces one quotient
// bit per clock and supports signed or unsigned operands, chosen per operation.
// The unit uses a Start/Busy/Done handshake. It is intended as a multi-cycle
// arithmetic unit that sits behind a datapath controller.
//
// Parameters
//   W        operand/result width in bits (W >= 4), default 32
//   CW       iteration counter width, derived as $clog2(W+1) (local, fixed)
//
// Ports
//   CLK      in   clock; all state changes on the rising edge
//   RST      in   synchronous reset, active-high; overrides everything
//   Start    in   operation request; sampled only while idle
//   Signed   in   1 = two's-complement operands, 0 = unsigned
//   Num      in   dividend (W bits), captured with Start
//   Den      in   divisor  (W bits), captured with Start
//   Coc      out  quotient, registered, held until the next Done
//   Res      out  remainder, registered, held until the next Done
//   Busy     out  high while an operation is in progress
//   Done     out  one-cycle pulse when Coc/Res/DivZero are updated
//   DivZero  out  1 if the last completed operation had Den == 0
//   Abort    in   (only with DIVISOR_ABORT_EN) cancels the running operation
//
// Build option
//   DIVISOR_ABORT_EN  adds the Abort input. Abort while Busy returns the unit
//                     to idle with no Done, and the published results are left
//                     untouched. RST still takes priority over Abort.
//
// Latency
//   Normal operation: Start accepted at edge k, results and Done appear after
//   edge k+W+1. Divide-by-zero: results and Done appear after edge k+2.
// -----------------------------------------------------------------------------
module divisor_param #(
  parameter int W = 32
) (
`ifdef DIVISOR_ABORT_EN
  input  logic         Abort,
`endif
  input  logic         CLK,
  input  logic         RST,
  input  logic         Start,
  input  logic         Signed,
  input  logic [W-1:0] Num,
  input  logic [W-1:0] Den,
  output logic [W-1:0] Coc,
  output logic [W-1:0] Res,
  output logic         Busy,
  output logic         Done,
  output logic         DivZero
);

  localparam int CW = $clog2(W + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  localparam logic [W-1:0]  ZERO_W = {W{1'b0}};
  localparam logic [W-1:0]  ONES_W = {W{1'b1}};
  localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C  = {{(CW-1){1'b0}}, 1'b1};

  // Two's-complement negation on W bits. MIN negates to itself, which gives
  // the wrap behaviour of MIN / -1.
  function automatic logic [W-1:0] neg_f(input logic [W-1:0] v);
    neg_f = ~v + {{(W-1){1'b0}}, 1'b1};
  endfunction

  // State and datapath registers
  logic [1:0]    state_q, state_d;
  logic [W-1:0]  acc_q,   acc_d;     // partial remainder
  logic [W-1:0]  quo_q,   quo_d;     // dividend shifting out / quotient in
  logic [W-1:0]  m_q,     m_d;       // divisor magnitude
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          sn_q,    sn_d;      // dividend was negative (signed mode)
  logic          sd_q,    sd_d;      // divisor was negative (signed mode)
  logic          zero_q,  zero_d;    // divide-by-zero operation in flight

  // Output registers
  logic [W-1:0]  coc_q,   coc_d;
  logic [W-1:0]  res_q,   res_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;
  logic          dz_q,    dz_d;

  // Datapath step signals
  logic [W:0]    a_ext_s;
  logic          ge_s;
  logic [W-1:0]  diff_s;
  logic          abort_s;

`ifdef DIVISOR_ABORT_EN
  assign abort_s = Abort & busy_q;
`else
  assign abort_s = 1'b0;
`endif

  // One restoring step. The shifted partial remainder keeps the bit that
  // leaves ACCU, so the compare is W+1 bits wide. A W-bit subtraction is
  // enough for the result, because the difference fits in W bits whenever
  // the compare succeeds.
  always_comb begin
    a_ext_s = {acc_q, quo_q[W-1]};
    ge_s    = (a_ext_s >= {1'b0, m_q});
    diff_s  = a_ext_s[W-1:0] - m_q;
  end

  // Next-state logic for the control FSM and the datapath registers
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    quo_d   = quo_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    sn_d    = sn_q;
    sd_d    = sd_q;
    zero_d  = zero_q;
    coc_d   = coc_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;

    if (abort_s) begin
      // Cancelled operation: drop to idle and leave the published results alone.
      state_d = ST_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            sn_d   = Signed & Num[W-1];
            sd_d   = Signed & Den[W-1];
            quo_d  = (Signed & Num[W-1]) ? neg_f(Num) : Num;
            m_d    = (Signed & Den[W-1]) ? neg_f(Den) : Den;
            acc_d  = ZERO_W;
            busy_d = 1'b1;
            if (Den == ZERO_W) begin
              // Divide-by-zero skips the iterations. It holds in FIX for one
              // cycle so that its results appear two edges after Start.
              zero_d  = 1'b1;
              cnt_d   = ONE_C;
              state_d = ST_FIX;
            end else begin
              zero_d  = 1'b0;
              cnt_d   = CW'(W);
              state_d = ST_CALC;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_CALC: begin
          if (ge_s) begin
            acc_d = diff_s;
            quo_d = {quo_q[W-2:0], 1'b1};
          end else begin
            acc_d = a_ext_s[W-1:0];
            quo_d = {quo_q[W-2:0], 1'b0};
          end
          cnt_d = cnt_q - ONE_C;
          if (cnt_q == ONE_C) begin
            state_d = ST_FIX;
          end else begin
            state_d = ST_CALC;
          end
        end

        ST_FIX: begin
          if (zero_q && (cnt_q != ZERO_C)) begin
            cnt_d   = ZERO_C;
            state_d = ST_FIX;
          end else begin
            if (zero_q) begin
              // Re-applying the capture negation restores Num unmodified.
              coc_d = ONES_W;
              res_d = sn_q ? neg_f(quo_q) : quo_q;
              dz_d  = 1'b1;
            end else begin
              coc_d = (sn_q ^ sd_q) ? neg_f(quo_q) : quo_q;
              res_d = sn_q ? neg_f(acc_q) : acc_q;
              dz_d  = 1'b0;
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = ZERO_C;
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      acc_q   <= ZERO_W;
      quo_q   <= ZERO_W;
      m_q     <= ZERO_W;
      cnt_q   <= ZERO_C;
      sn_q    <= 1'b0;
      sd_q    <= 1'b0;
      zero_q  <= 1'b0;
      coc_q   <= ZERO_W;
      res_q   <= ZERO_W;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      quo_q   <= quo_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      sn_q    <= sn_d;
      sd_q    <= sd_d;
      zero_q  <= zero_d;
      coc_q   <= coc_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign Coc     = coc_q;
  assign Res     = res_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign DivZero = dz_q;

endmodule

// File: tb/tb_divisor_param.sv
// -----------------------------------------------------------------------------
// tb_divisor_param
// Directed bench for divisor_param with W = 8. A behavioural reference model
// computes quotient and remainder with plain integer division. It also works
// out the expected handshake timing from the documented latencies. One compare
// process checks every output against the model on each falling edge. The
// directed tasks additionally pin results, latency and Busy length to
// hand-computed literals.
// -----------------------------------------------------------------------------
module tb_divisor_param;
  localparam int W = 8;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Start;
  logic       Signed;
  logic [7:0] Num;
  logic [7:0] Den;
  logic [7:0] Coc;
  logic [7:0] Res;
  logic       Busy;
  logic       Done;
  logic       DivZero;
`ifdef DIVISOR_ABORT_EN
  logic       Abort;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  divisor_param #(.W(W)) dut (
`ifdef DIVISOR_ABORT_EN
    .Abort   (Abort),
`endif
    .CLK     (CLK),
    .RST     (RST),
    .Start   (Start),
    .Signed  (Signed),
    .Num     (Num),
    .Den     (Den),
    .Coc     (Coc),
    .Res     (Res),
    .Busy    (Busy),
    .Done    (Done),
    .DivZero (DivZero)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference result: {quotient, remainder, divzero}
  function automatic logic [16:0] ref_div(input logic sgn, input logic [7:0] n, input logic [7:0] d);
    int a;
    int b;
    int q;
    int r;
    if (d == 8'h00) return {8'hFF, n, 1'b1};
    if (sgn) begin
      a = {{24{n[7]}}, n};
      b = {{24{d[7]}}, d};
    end else begin
      a = {24'h0, n};
      b = {24'h0, d};
    end
    q = a / b;
    r = a % b;
    return {q[7:0], r[7:0], 1'b0};
  endfunction

  // ---------------- reference model ----------------
  logic       m_busy, m_done, m_dz, p_dz;
  logic [7:0] m_coc, m_res, p_coc, p_res;
  int         m_cnt;
  logic       ab_s;
`ifdef DIVISOR_ABORT_EN
  assign ab_s = Abort;
`else
  assign ab_s = 1'b0;
`endif

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (RST) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
      m_coc <= 8'h00; m_res <= 8'h00; m_cnt <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy && ab_s) begin
        m_busy <= 1'b0;
      end else if (m_busy && m_cnt == 1) begin
        m_busy <= 1'b0; m_done <= 1'b1; m_cnt <= 0;
        m_coc <= p_coc; m_res <= p_res; m_dz <= p_dz;
      end else if (m_busy) begin
        m_cnt <= m_cnt - 1;
      end else if (Start) begin
        {p_coc, p_res, p_dz} <= ref_div(Signed, Num, Den);
        m_cnt  <= (Den == 8'h00) ? 2 : W + 1;
        m_busy <= 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("busy",    32'(Busy),    32'(m_busy));
      chk("done",    32'(Done),    32'(m_done));
      chk("coc",     32'(Coc),     32'(m_coc));
      chk("res",     32'(Res),     32'(m_res));
      chk("divzero", 32'(DivZero), 32'(m_dz));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic run_op(input logic sgn, input logic [7:0] n, input logic [7:0] d,
                        input logic [7:0] ec, input logic [7:0] er, input logic ez, input int lat);
    int cnt;
    int bcnt;
    bit seen;
    Signed = sgn; Num = n; Den = d; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0; Num = 8'h5A; Den = 8'h33;   // operands change after capture
    cnt = 0; bcnt = 0; seen = 1'b0;
    if (Busy) bcnt++;
    while (!seen && cnt < 40) begin
      @(posedge CLK); #1;
      cnt++;
      if (Done) seen = 1'b1;
      else if (Busy) bcnt++;
    end
    chk("op_done_seen", 32'(seen), 32'd1);
    chk("op_latency",   32'(cnt),  32'(lat));
    chk("op_busy_len",  32'(bcnt), 32'(lat));
    chk("op_coc",       32'(Coc),  32'(ec));
    chk("op_res",       32'(Res),  32'(er));
    chk("op_divzero",   32'(DivZero), 32'(ez));
  endtask

  task automatic expect_no_done(input string name, input int ncyc);
    int pulses;
    pulses = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge CLK); #1;
      if (Done) pulses++;
    end
    chk(name, 32'(pulses), 32'd0);
  endtask

  initial begin
    int t[3];
    int k;
    int guard;
    int cnt;
    bit seen;
    RST = 1'b1; Start = 1'b0; Signed = 1'b0; Num = 8'h00; Den = 8'h00;
`ifdef DIVISOR_ABORT_EN
    Abort = 1'b0;
`endif
    @(posedge CLK); @(posedge CLK); #1;
    chk_en = 1'b1;
    chk("rst_coc",  32'(Coc),  32'd0);
    chk("rst_res",  32'(Res),  32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_dz",   32'(DivZero), 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    run_op(1'b0, 8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 9);
    run_op(1'b1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 9);
    run_op(1'b1, 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 9);
    run_op(1'b0, 8'hC8, 8'h00, 8'hFF, 8'hC8, 1'b1, 2);
    run_op(1'b1, 8'hC8, 8'h00, 8'hFF, 8'hC8, 1'b1, 2);
    run_op(1'b0, 8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 9);   // clears DivZero
    run_op(1'b1, 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 9);
    run_op(1'b0, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 9);
    run_op(1'b1, 8'h81, 8'h07, 8'hEE, 8'hFF, 1'b0, 9);   // -127/7 = -18 r -1
    run_op(1'b0, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 9);
    run_op(1'b0, 8'hC8, 8'hC9, 8'h00, 8'hC8, 1'b0, 9);

    // Start held high: a new op is accepted in every Done cycle
    Signed = 1'b0; Num = 8'd100; Den = 8'd7; Start = 1'b1;
    k = 0; guard = 0;
    while (k < 3 && guard < 100) begin
      @(posedge CLK); #1;
      guard++;
      if (Done) begin
        t[k] = cyc;
        k++;
      end
    end
    Start = 1'b0;
    chk("b2b_pulses", 32'(k), 32'd3);
    if (k == 3) begin
      chk("b2b_gap1", 32'(t[1] - t[0]), 32'd10);
      chk("b2b_gap2", 32'(t[2] - t[1]), 32'd10);
    end
    expect_no_done("b2b_tail", 12);

    // Second Start mid-operation is ignored
    Signed = 1'b0; Num = 8'd100; Den = 8'd7; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    Num = 8'd9; Den = 8'd3; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    cnt = 0; seen = 1'b0;
    while (!seen && cnt < 40) begin
      @(posedge CLK); #1;
      cnt++;
      if (Done) seen = 1'b1;
    end
    chk("mid_done_seen", 32'(seen), 32'd1);
    chk("mid_coc", 32'(Coc), 32'h0E);
    chk("mid_res", 32'(Res), 32'h02);
    expect_no_done("mid_ignored", 14);

    // RST at iteration 4
    Signed = 1'b0; Num = 8'd100; Den = 8'd7; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("rst4_coc",  32'(Coc),  32'd0);
    chk("rst4_res",  32'(Res),  32'd0);
    chk("rst4_busy", 32'(Busy), 32'd0);
    chk("rst4_done", 32'(Done), 32'd0);
    chk("rst4_dz",   32'(DivZero), 32'd0);
    expect_no_done("rst4_no_done", 15);
    run_op(1'b1, 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 9);

`ifdef DIVISOR_ABORT_EN
    // Abort at iteration 3 of 100/7; previous result (0xFD/0xFF) retained
    Signed = 1'b0; Num = 8'd100; Den = 8'd7; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    Abort = 1'b1;
    @(posedge CLK); #1;
    Abort = 1'b0;
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_coc",  32'(Coc),  32'hFD);
    chk("abort_res",  32'(Res),  32'hFF);
    expect_no_done("abort_no_done", 12);
    run_op(1'b0, 8'd9, 8'd3, 8'h03, 8'h00, 1'b0, 9);
`endif

    repeat (2) @(posedge CLK);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
